// File: rtl/scc_arb_pkg.sv
// scc_arb_pkg: shared state type and constants for scc_ram_arbiter.
package scc_arb_pkg;
    localparam int unsigned NUM_PORTS = 2;
    localparam logic [7:0]  IDLE_DATA = 8'hFF;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_e;
endpackage

// File: rtl/scc_rr_arbiter.sv
// scc_rr_arbiter: 2-way round-robin grant; prio selects the port that wins a tie.
module scc_rr_arbiter
    import scc_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 prio,
    output logic [NUM_PORTS-1:0] gnt
);
    assign gnt[0] = req[0] & (~req[1] | ~prio);
    assign gnt[1] = req[1] & (~req[0] | prio);
endmodule

// File: rtl/scc_ram_arbiter.sv
// scc_ram_arbiter: two-port round-robin arbiter in front of a single-access RAM.
// Define SCC_ARB_TIMEOUT_EN to abort WAIT after RAM_TIMEOUT cycles without ramack.
module scc_ram_arbiter
    import scc_arb_pkg::*;
#(
    parameter int unsigned RAM_TIMEOUT = 15
)
(
    input  logic        clk21m,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        wrt0,
    input  logic        wrt1,
    input  logic [20:0] adr0,
    input  logic [20:0] adr1,
    input  logic [7:0]  dbo0,
    input  logic [7:0]  dbo1,
    output logic        ack0,
    output logic        ack1,
    output logic [7:0]  dbi0,
    output logic [7:0]  dbi1,
    output logic        ramreq,
    output logic        ramwrt,
    output logic [20:0] ramadr,
    output logic [7:0]  ramdbo,
    input  logic        ramack,
    input  logic [7:0]  ramdbi
);
    if (RAM_TIMEOUT < 2 || RAM_TIMEOUT > 255) begin : g_bad_timeout
        $error("RAM_TIMEOUT must lie in 2..255");
    end

    state_e                state_q, state_d;
    logic                  gnt_q, gnt_d;
    logic                  prio_q, prio_d;
    logic                  mask_q, mask_d;
    logic                  ramwrt_q, ramwrt_d;
    logic [20:0]           ramadr_q, ramadr_d;
    logic [7:0]            ramdbo_q, ramdbo_d;
    logic [7:0]            dbi0_q, dbi0_d;
    logic [7:0]            dbi1_q, dbi1_d;
    logic [7:0]            rd_data;
    logic                  timeout;
    logic [NUM_PORTS-1:0]  req_vec, gnt;

    // The port just served is kept out of the first IDLE cycle, while its req is still falling.
    assign req_vec = {req1, req0} & ~(mask_q ? (gnt_q ? 2'b10 : 2'b01) : 2'b00);
    assign mask_d  = state_q == ST_DONE;

    scc_rr_arbiter u_arb (
        .req  (req_vec),
        .prio (prio_q),
        .gnt  (gnt)
    );

`ifdef SCC_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    assign cnt_d   = state_q == ST_WAIT ? cnt_q + 8'd1 : 8'd0;
    assign timeout = state_q == ST_WAIT && cnt_q == 8'(RAM_TIMEOUT - 1);
    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) cnt_q <= 8'd0;
        else       cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        prio_d   = prio_q;
        ramwrt_d = ramwrt_q;
        ramadr_d = ramadr_q;
        ramdbo_d = ramdbo_q;
        dbi0_d   = dbi0_q;
        dbi1_d   = dbi1_q;
        rd_data  = ramack ? ramdbi : IDLE_DATA;
        case (state_q)
            ST_IDLE: if (|gnt) begin
                state_d  = ST_ISSUE;
                gnt_d    = gnt[1];
                prio_d   = gnt[0];
                ramwrt_d = gnt[1] ? wrt1 : wrt0;
                ramadr_d = gnt[1] ? adr1 : adr0;
                ramdbo_d = gnt[1] ? dbo1 : dbo0;
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: if (ramack || timeout) begin
                state_d = ST_DONE;
                dbi0_d  = (!ramwrt_q && !gnt_q) ? rd_data : dbi0_q;
                dbi1_d  = (!ramwrt_q &&  gnt_q) ? rd_data : dbi1_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            gnt_q    <= 1'b0;
            prio_q   <= 1'b0;
            mask_q   <= 1'b0;
            ramwrt_q <= 1'b0;
            ramadr_q <= '0;
            ramdbo_q <= '0;
            dbi0_q   <= IDLE_DATA;
            dbi1_q   <= IDLE_DATA;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            prio_q   <= prio_d;
            mask_q   <= mask_d;
            ramwrt_q <= ramwrt_d;
            ramadr_q <= ramadr_d;
            ramdbo_q <= ramdbo_d;
            dbi0_q   <= dbi0_d;
            dbi1_q   <= dbi1_d;
        end
    end

    assign ramreq = state_q == ST_ISSUE;
    assign ack0   = state_q == ST_DONE && !gnt_q;
    assign ack1   = state_q == ST_DONE &&  gnt_q;
    assign ramwrt = ramwrt_q;
    assign ramadr = ramadr_q;
    assign ramdbo = ramdbo_q;
    assign dbi0   = dbi0_q;
    assign dbi1   = dbi1_q;
endmodule

// File: tb/tb_scc_ram_arbiter.sv
// tb_scc_ram_arbiter: directed and randomized checks of scc_ram_arbiter against a transaction-level model.
module tb_scc_ram_arbiter;
    localparam int T = 15;

    logic        clk21m = 1'b0;
    logic        reset  = 1'b1;
    logic [1:0]  req    = 2'b00;
    logic [1:0]  wrt    = 2'b00;
    logic [20:0] adr [2];
    logic [7:0]  dbo [2];
    logic        ramack = 1'b0;
    logic [7:0]  ramdbi = 8'h00;
    logic        ack0, ack1, ramreq, ramwrt;
    logic [7:0]  dbi0, dbi1, ramdbo;
    logic [20:0] ramadr;
    int          total = 0;
    int          bad   = 0;

    always #23 clk21m = ~clk21m;

    scc_ram_arbiter #(.RAM_TIMEOUT(T)) dut (
        .clk21m (clk21m),
        .reset  (reset),
        .req0   (req[0]),
        .req1   (req[1]),
        .wrt0   (wrt[0]),
        .wrt1   (wrt[1]),
        .adr0   (adr[0]),
        .adr1   (adr[1]),
        .dbo0   (dbo[0]),
        .dbo1   (dbo[1]),
        .ack0   (ack0),
        .ack1   (ack1),
        .dbi0   (dbi0),
        .dbi1   (dbi1),
        .ramreq (ramreq),
        .ramwrt (ramwrt),
        .ramadr (ramadr),
        .ramdbo (ramdbo),
        .ramack (ramack),
        .ramdbi (ramdbi)
    );

    task automatic step();
        @(posedge clk21m);
        @(negedge clk21m);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        req    = 2'b00;
        ramack = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req    = 2'b11;
        wrt    = 2'($urandom);
        ramack = 1'b1;
        ramdbi = 8'($urandom);
        reset  = 1'b1;
        step();
        step();
        total++;
        if ({ack1, ack0, ramreq, ramwrt} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctl got=%b exp=0000", {ack1, ack0, ramreq, ramwrt});
        end
        total++;
        if (ramadr !== 21'h0) begin bad++; $display("FAIL reset_adr got=%h exp=0", ramadr); end
        total++;
        if (ramdbo !== 8'h00) begin bad++; $display("FAIL reset_dbo got=%h exp=00", ramdbo); end
        total++;
        if ({dbi1, dbi0} !== 16'hFFFF) begin bad++; $display("FAIL reset_dbi got=%h exp=ffff", {dbi1, dbi0}); end
        reset  = 1'b0;
        req    = 2'b00;
        ramack = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        req[0] = 1'b1; wrt[0] = 1'b0; adr[0] = 21'h0_0ABC; dbo[0] = 8'h00;
        step();
        total++;
        if ({ramreq, ack0, ramwrt, ramadr} !== {3'b100, 21'h0_0ABC}) begin
            bad++; $display("FAIL rd_issue got=%b/%h exp=100/00abc", {ramreq, ack0, ramwrt}, ramadr);
        end
        ramack = 1'b1; ramdbi = 8'h33;
        step();
        total++;
        if ({ramreq, ack0, ack1} !== 3'b000) begin
            bad++; $display("FAIL rd_wait got=%b exp=000", {ramreq, ack0, ack1});
        end
        ramack = 1'b1; ramdbi = 8'h5A;
        step();
        total++;
        if ({ack1, ack0, dbi0} !== {2'b01, 8'h5A}) begin
            bad++; $display("FAIL rd_ack got=%b/%h exp=01/5a", {ack1, ack0}, dbi0);
        end
        ramack = 1'b0; req[0] = 1'b0;
        step();
        total++;
        if ({ack0, dbi0} !== {1'b0, 8'h5A}) begin
            bad++; $display("FAIL rd_hold got=%b/%h exp=0/5a", ack0, dbi0);
        end
    endtask

    task automatic test_write_port1();
        req[1] = 1'b1; wrt[1] = 1'b1; adr[1] = 21'h1_2345; dbo[1] = 8'hA5;
        step();
        total++;
        if ({ramreq, ramwrt, ramadr, ramdbo} !== {2'b11, 21'h1_2345, 8'hA5}) begin
            bad++; $display("FAIL wr_issue got=%b/%h/%h exp=11/12345/a5", {ramreq, ramwrt}, ramadr, ramdbo);
        end
        step();
        ramack = 1'b1; ramdbi = 8'h3C;
        step();
        total++;
        if ({ack1, ack0, dbi1, dbi0} !== {2'b10, 8'hFF, 8'h5A}) begin
            bad++; $display("FAIL wr_ack got=%b/%h/%h exp=10/ff/5a", {ack1, ack0}, dbi1, dbi0);
        end
        ramack = 1'b0; req[1] = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int nack = 0;
        int exp_port = 0;
        bit issued = 1'b0;
        do_reset();
        wrt = 2'b00;
        req = 2'b11;
        for (int c = 0; c < 100 && nack < 8; c++) begin
            step();
            ramack = 1'b0;
            if (ack0 || ack1) begin
                total++;
                if ({ack1, ack0} !== (exp_port == 1 ? 2'b10 : 2'b01)) begin
                    bad++; $display("FAIL b2b_order n=%0d got=%b exp_port=%0d", nack, {ack1, ack0}, exp_port);
                end
                req[exp_port] = 1'b0;
                exp_port ^= 1;
                nack++;
            end else begin
                req = 2'b11;
            end
            if (ramreq) issued = 1'b1;
            else if (issued) begin ramack = 1'b1; ramdbi = 8'($urandom); issued = 1'b0; end
        end
        total++;
        if (nack != 8) begin bad++; $display("FAIL b2b_count got=%0d exp=8", nack); end
        req = 2'b00; ramack = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] dbi_m [2];
        logic [7:0] rd;
        logic [1:0] elig;
        bit out_q, ack_due, was_ack, exp_grant, issued_now, acked_now;
        int exp_port, gport, last_port, wait_n, max_age;
        int age [2];
        do_reset();
        dbi_m[0] = 8'hFF; dbi_m[1] = 8'hFF; rd = 8'h00;
        out_q = 0; ack_due = 0; was_ack = 0; exp_grant = 0;
        exp_port = 0; gport = 0; last_port = 1; wait_n = 0; max_age = 0;
        age[0] = 0; age[1] = 0;
        for (int c = 0; c < 400; c++) begin
            issued_now = 0; acked_now = 0;
            step();
            total++;
            if (ramreq !== exp_grant) begin
                bad++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, ramreq, exp_grant);
            end else if (ramreq) begin
                total++;
                if ({ramwrt, ramadr, ramdbo} !== {wrt[exp_port], adr[exp_port], dbo[exp_port]}) begin
                    bad++; $display("FAIL rnd_fields c=%0d got=%b/%h/%h exp=%b/%h/%h", c, ramwrt, ramadr, ramdbo,
                                    wrt[exp_port], adr[exp_port], dbo[exp_port]);
                end
                out_q = 1; gport = exp_port; last_port = exp_port;
                wait_n = $urandom_range(0, 3); issued_now = 1;
            end
            total++;
            if ({ack1, ack0} !== (ack_due ? (gport == 1 ? 2'b10 : 2'b01) : 2'b00)) begin
                bad++; $display("FAIL rnd_ack c=%0d got=%b due=%b port=%0d", c, {ack1, ack0}, ack_due, gport);
            end
            if (ack_due) begin
                if (!wrt[gport]) dbi_m[gport] = rd;
                req[gport] = 1'b0; out_q = 0; ack_due = 0; acked_now = 1;
            end
            total++;
            if ({dbi1, dbi0} !== {dbi_m[1], dbi_m[0]}) begin
                bad++; $display("FAIL rnd_dbi c=%0d got=%h exp=%h", c, {dbi1, dbi0}, {dbi_m[1], dbi_m[0]});
            end
            ramack = 1'b0;
            if (out_q && !issued_now) begin
                if (wait_n == 0) begin ramack = 1'b1; ramdbi = 8'($urandom); rd = ramdbi; ack_due = 1; end
                else wait_n--;
            end else if (!out_q) begin
                ramack = ($urandom_range(0, 7) == 0);
                ramdbi = 8'($urandom);
            end
            for (int p = 0; p < 2; p++) begin
                if (req[p]) begin
                    age[p]++;
                    if (age[p] > max_age) max_age = age[p];
                end else if (!(acked_now && gport == p) && $urandom_range(0, 2) == 0) begin
                    req[p] = 1'b1; wrt[p] = 1'($urandom); adr[p] = 21'($urandom); dbo[p] = 8'($urandom); age[p] = 0;
                end
            end
            elig      = req & ~(was_ack ? (last_port == 1 ? 2'b10 : 2'b01) : 2'b00);
            exp_grant = !out_q && !acked_now && elig != 2'b00;
            exp_port  = elig == 2'b11 ? 1 - last_port : (elig[1] ? 1 : 0);
            was_ack   = acked_now;
        end
        total++;
        if (max_age > 60) begin bad++; $display("FAIL rnd_starve got=%0d exp<=60", max_age); end
        req = 2'b00; ramack = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit issued = 1'b0;
        bit done = 1'b0;
        do_reset();
        req[0] = 1'b1; wrt[0] = 1'b0; adr[0] = 21'h1_FFFF;
        step();
        step();
        reset = 1'b1;
        #1;
        total++;
        if ({ack1, ack0, ramreq, ramwrt, ramadr, ramdbo, dbi1, dbi0} !== {4'b0000, 21'h0, 8'h00, 16'hFFFF}) begin
            bad++; $display("FAIL mid_reset got=%b/%h/%h/%h", {ack1, ack0, ramreq, ramwrt}, ramadr, ramdbo, {dbi1, dbi0});
        end
        ramack = 1'b1; ramdbi = 8'h11;
        step();
        total++;
        if ({ack1, ack0} !== 2'b00) begin bad++; $display("FAIL mid_noack got=%b exp=00", {ack1, ack0}); end
        step();
        reset = 1'b0; ramack = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            step();
            ramack = 1'b0;
            if (ack0) done = 1'b1;
            else if (ramreq) issued = 1'b1;
            else if (issued) begin ramack = 1'b1; ramdbi = 8'hC3; issued = 1'b0; end
        end
        total++;
        if ({done, dbi0} !== {1'b1, 8'hC3}) begin
            bad++; $display("FAIL mid_resume got=%b/%h exp=1/c3", done, dbi0);
        end
        req[0] = 1'b0; ramack = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int ack_cyc = -1;
        step();
        req[0] = 1'b1; wrt[0] = 1'b0; ramack = 1'b0;
        for (int c = 1; c <= 40 && ack_cyc < 0; c++) begin
            step();
            if (ack0) ack_cyc = c;
        end
`ifdef SCC_ARB_TIMEOUT_EN
        total++;
        if (ack_cyc != T + 2) begin bad++; $display("FAIL to_latency got=%0d exp=%0d", ack_cyc, T + 2); end
        total++;
        if (dbi0 !== 8'hFF) begin bad++; $display("FAIL to_data got=%h exp=ff", dbi0); end
`else
        total++;
        if (ack_cyc != -1) begin bad++; $display("FAIL to_noack got=%0d exp=-1", ack_cyc); end
`endif
        req[0] = 1'b0;
        do_reset();
    endtask

    initial begin
        adr[0] = '0; adr[1] = '0; dbo[0] = '0; dbo[1] = '0;
        test_reset();
        test_single_read();
        test_write_port1();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
